// File: rtl/axi_lite_sram_slave.sv
// rtl/axi_lite_sram_slave.sv - AXI4-Lite slave over a 1R1W word SRAM; optional AXI_MEM_ALIGN_CHECK_EN
module axi_lite_sram_slave #(
  parameter int                   ADDR_BITS   = 32,
  parameter int                   DATA_BITS   = 32,
  parameter int                   MEM_WORDS   = 16384,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR   = '0,
  parameter int                   RD_LATENCY  = 1,
  parameter int                   RFIFO_DEPTH = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [ADDR_BITS-1:0]   ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [DATA_BITS-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic [ADDR_BITS-1:0]   AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_BITS-1:0]   WDATA,
  input  logic [DATA_BITS/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int LSB       = $clog2(STRB_BITS);
  localparam int IDX_BITS  = $clog2(MEM_WORDS);
  localparam int PTR_BITS  = $clog2(RFIFO_DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Address decode (read and write ports each have their own)
  // ------------------------------------------------------------------
  logic [ADDR_BITS-1:0] ar_woff;
  logic                 ar_ok;
  logic [IDX_BITS-1:0]  ar_idx;

  logic [ADDR_BITS-1:0] c_addr;
  logic [DATA_BITS-1:0] c_data;
  logic [STRB_BITS-1:0] c_strb;
  logic [ADDR_BITS-1:0] c_woff;
  logic                 c_ok;
  logic [IDX_BITS-1:0]  c_idx;

  assign ar_woff = (ARADDR - BASE_ADDR) >> LSB;
  assign ar_ok   = (ARADDR >= BASE_ADDR) && (ar_woff < ADDR_BITS'(MEM_WORDS))
                   && !(ALIGN_CHECK && (ARADDR[LSB-1:0] != '0));
  assign ar_idx  = ar_woff[IDX_BITS-1:0];

  assign c_woff  = (c_addr - BASE_ADDR) >> LSB;
  assign c_ok    = (c_addr >= BASE_ADDR) && (c_woff < ADDR_BITS'(MEM_WORDS))
                   && !(ALIGN_CHECK && (c_addr[LSB-1:0] != '0));
  assign c_idx   = c_woff[IDX_BITS-1:0];

  // ------------------------------------------------------------------
  // SRAM: combinational read samples contents before this edge's write,
  // which gives read-first behaviour on a same-cycle collision.
  // ------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [MEM_WORDS];
  logic                 w_commit;
  logic [DATA_BITS-1:0] rd_word;
  logic [1:0]           rd_resp;

  assign rd_word = ar_ok ? mem[ar_idx] : '0;
  assign rd_resp = ar_ok ? RESP_OKAY : RESP_SLVERR;

  // Byte-lane write of a committed in-range AXI write
  always_ff @(posedge ACLK) begin
    if (w_commit && c_ok) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (c_strb[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  // ------------------------------------------------------------------
  // Read path: credits bound everything in the pipe plus the FIFO
  // ------------------------------------------------------------------
  logic                ar_hs;
  logic                r_hs;
  logic [CNT_BITS-1:0] credits;

  assign ARREADY = (credits < CNT_BITS'(RFIFO_DEPTH));
  assign ar_hs   = ARVALID && ARREADY;
  assign r_hs    = RVALID && RREADY;

  // Outstanding-read credit counter
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      credits <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   credits <= credits + CNT_BITS'(1);
        2'b01:   credits <= credits - CNT_BITS'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Result entering the response FIFO after RD_LATENCY cycles
  logic                 q_valid;
  logic [DATA_BITS-1:0] q_data;
  logic [1:0]           q_resp;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign q_valid = ar_hs;
      assign q_data  = rd_word;
      assign q_resp  = rd_resp;
    end else begin : g_latn
      localparam int NST = RD_LATENCY - 1;
      logic                 p_valid [NST];
      logic [DATA_BITS-1:0] p_data  [NST];
      logic [1:0]           p_resp  [NST];

      // Delay line carrying the SRAM result toward the FIFO
      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          for (int i = 0; i < NST; i++) begin
            p_valid[i] <= 1'b0;
            p_data[i]  <= '0;
            p_resp[i]  <= RESP_OKAY;
          end
        end else begin
          p_valid[0] <= ar_hs;
          p_data[0]  <= rd_word;
          p_resp[0]  <= rd_resp;
          for (int i = 1; i < NST; i++) begin
            p_valid[i] <= p_valid[i-1];
            p_data[i]  <= p_data[i-1];
            p_resp[i]  <= p_resp[i-1];
          end
        end
      end

      assign q_valid = p_valid[NST-1];
      assign q_data  = p_data[NST-1];
      assign q_resp  = p_resp[NST-1];
    end
  endgenerate

  logic [PTR_BITS:0]    wr_ptr;
  logic [PTR_BITS:0]    rd_ptr;
  logic [DATA_BITS-1:0] f_data [RFIFO_DEPTH];
  logic [1:0]           f_resp [RFIFO_DEPTH];

  // Response FIFO pointers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (q_valid) wr_ptr <= wr_ptr + (PTR_BITS+1)'(1);
      if (r_hs)    rd_ptr <= rd_ptr + (PTR_BITS+1)'(1);
    end
  end

  // Response FIFO storage
  always_ff @(posedge ACLK) begin
    if (q_valid) begin
      f_data[wr_ptr[PTR_BITS-1:0]] <= q_data;
      f_resp[wr_ptr[PTR_BITS-1:0]] <= q_resp;
    end
  end

  assign RVALID = (wr_ptr != rd_ptr);
  assign RDATA  = RVALID ? f_data[rd_ptr[PTR_BITS-1:0]] : '0;
  assign RRESP  = RVALID ? f_resp[rd_ptr[PTR_BITS-1:0]] : RESP_OKAY;

  // ------------------------------------------------------------------
  // Write path: AW and W accepted independently, one write outstanding
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;

  w_state_t             w_state;
  w_state_t             w_state_nx;
  logic                 aw_latch;
  logic                 w_latch;
  logic [ADDR_BITS-1:0] aw_addr_q;
  logic [DATA_BITS-1:0] w_data_q;
  logic [STRB_BITS-1:0] w_strb_q;
  logic [1:0]           bresp_q;

  assign c_addr = (w_state == W_HAVE_AW) ? aw_addr_q : AWADDR;
  assign c_data = (w_state == W_HAVE_W)  ? w_data_q  : WDATA;
  assign c_strb = (w_state == W_HAVE_W)  ? w_strb_q  : WSTRB;
  assign BRESP  = bresp_q;

  // Write FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nx;
  end

  // Write FSM next state, channel readies and commit strobe
  always_comb begin
    w_state_nx = w_state;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    w_commit   = 1'b0;
    aw_latch   = 1'b0;
    w_latch    = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        if (AWVALID && WVALID) begin
          w_commit   = 1'b1;
          w_state_nx = W_RESP;
        end else if (AWVALID) begin
          aw_latch   = 1'b1;
          w_state_nx = W_HAVE_AW;
        end else if (WVALID) begin
          w_latch    = 1'b1;
          w_state_nx = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        WREADY = 1'b1;
        if (WVALID) begin
          w_commit   = 1'b1;
          w_state_nx = W_RESP;
        end
      end
      W_HAVE_W: begin
        AWREADY = 1'b1;
        if (AWVALID) begin
          w_commit   = 1'b1;
          w_state_nx = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Holding registers for whichever half arrived first, and the B response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_latch) aw_addr_q <= AWADDR;
      if (w_latch) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (w_commit) bresp_q <= c_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb/tb_axi_lite_sram_slave.sv - scoreboard bench for axi_lite_sram_slave
module tb_axi_lite_sram_slave;
  localparam int          MW    = 16384;
  localparam int          LAT   = 1;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef AXI_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;

  always #5 ACLK = ~ACLK;

  axi_lite_sram_slave #(
    .ADDR_BITS(32), .DATA_BITS(32), .MEM_WORDS(MW), .BASE_ADDR(BASE),
    .RD_LATENCY(LAT), .RFIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rsp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ar_cnt = 0;
  bit          rand_done = 1'b0;
  rsp_t        rexp[$];
  logic [1:0]  bexp[$];
  logic [31:0] aw_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] mem_m [int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s", name, what);
  endtask

  function automatic bit m_ok(input logic [31:0] a);
    logic [31:0] w;
    if (a < BASE) return 1'b0;
    w = (a - BASE) / 4;
    if (w >= MW) return 1'b0;
    if (ALIGN && (a[1:0] != 2'b00)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_word(input int k);
    return mem_m.exists(k) ? mem_m[k] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 19);
    if (k < 16)      return 32'(k * 4 + $urandom_range(0, 3));
    else if (k < 18) return 32'(MW * 4 + $urandom_range(0, 64) * 4);
    else             return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
  endfunction

  // Reference model: observes handshakes before the edge they complete on.
  // Reads are evaluated before the write of the same edge is applied.
  always @(negedge ACLK) begin
    rsp_t        e;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] old;
    logic [3:0]  s;
    if (ARESETn) begin
      if (ARVALID && ARREADY) begin
        if (m_ok(ARADDR)) begin
          e.data = m_word(widx(ARADDR));
          e.resp = 2'b00;
        end else begin
          e.data = 32'h0;
          e.resp = 2'b10;
        end
        rexp.push_back(e);
        ar_cnt++;
      end
      if (AWVALID && AWREADY) aw_q.push_back(AWADDR);
      if (WVALID && WREADY) begin
        wd_q.push_back(WDATA);
        ws_q.push_back(WSTRB);
      end
      if (aw_q.size() > 0 && wd_q.size() > 0) begin
        a = aw_q.pop_front();
        d = wd_q.pop_front();
        s = ws_q.pop_front();
        if (m_ok(a)) begin
          old = m_word(widx(a));
          for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
          mem_m[widx(a)] = old;
          bexp.push_back(2'b00);
        end else begin
          bexp.push_back(2'b10);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every R/B handshake
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [1:0]  hold_r;
  always @(negedge ACLK) begin
    rsp_t e;
    if (!ARESETn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("r_hold_valid", RVALID, 1'b1);
        chk("r_hold_data", RDATA, hold_d);
        chk("r_hold_resp", RRESP, hold_r);
      end
      if (RVALID && RREADY) begin
        if (rexp.size() == 0) begin
          flag("r_unexpected", $sformatf("RDATA=%0h RRESP=%0h, required no response", RDATA, RRESP));
        end else begin
          e = rexp.pop_front();
          chk("rdata", RDATA, e.data);
          chk("rresp", RRESP, e.resp);
        end
      end
      if (BVALID && BREADY) begin
        if (bexp.size() == 0) flag("b_unexpected", $sformatf("BRESP=%0h, required no response", BRESP));
        else chk("bresp", BRESP, bexp.pop_front());
      end
      hold_v = RVALID && !RREADY;
      hold_d = RDATA;
      hold_r = RRESP;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_ar(input logic [31:0] a);
    ARADDR  = a;
    ARVALID = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge ACLK);
      if (ARREADY) break;
      if (n >= 300) begin flag("ar_timeout", "ARREADY low, required high"); break; end
    end
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a);
    AWADDR  = a;
    AWVALID = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge ACLK);
      if (AWREADY) break;
      if (n >= 300) begin flag("aw_timeout", "AWREADY low, required high"); break; end
    end
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    WDATA  = d;
    WSTRB  = s;
    WVALID = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge ACLK);
      if (WREADY) break;
      if (n >= 300) begin flag("w_timeout", "WREADY low, required high"); break; end
    end
    tick();
    WVALID = 1'b0;
  endtask

  task automatic drain();
    RREADY = 1'b1;
    BREADY = 1'b1;
    for (int n = 0; ; n++) begin
      tick();
      if (rexp.size() == 0 && bexp.size() == 0 && !BVALID) break;
      if (n >= 500) begin flag("drain_timeout", "responses outstanding, required none"); break; end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 ARESETn = 1'b0;
    #2;
    chk("rst_arready", ARREADY, 1'b1);
    chk("rst_awready", AWREADY, 1'b1);
    chk("rst_wready", WREADY, 1'b1);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_rresp", RRESP, 2'b00);
    chk("rst_bresp", BRESP, 2'b00);
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    tick();

    // Give the words used by the bench known contents
    for (int k = 0; k < 16; k++) begin
      fork
        do_aw(32'(k * 4));
        do_w($urandom, 4'hF);
      join
    end
    drain();

    // AW and W in the same cycle, then read back
    AWADDR = 32'h10; AWVALID = 1'b1;
    WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    chk("same_cycle_readies", {AWREADY, WREADY}, 2'b11);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("b_next_cycle", BVALID, 1'b1);
    chk("b_okay", BRESP, 2'b00);
    tick();
    chk("b_cleared", BVALID, 1'b0);
    chk("ready_after_b", {AWREADY, WREADY}, 2'b11);
    do_ar(32'h10);
    repeat (LAT - 1) tick();
    chk("rvalid_latency", RVALID, 1'b1);
    chk("rdata_deadbeef", RDATA, 32'hDEAD_BEEF);
    drain();

    // Partial strobe write
    fork
      do_aw(32'h10);
      do_w(32'h0000_1122, 4'b0011);
    join
    do_ar(32'h10);
    repeat (LAT - 1) tick();
    chk("rdata_partial", RDATA, 32'hDEAD_1122);
    drain();

    // Back-pressure: six ARs, four credits
    begin
      int base;
      RREADY = 1'b0;
      base = ar_cnt;
      fork
        begin
          for (int i = 0; i < 6; i++) do_ar(32'(i * 4));
        end
        begin
          repeat (10) tick();
          @(negedge ACLK);
          chk("ar_accepted_full", 64'(ar_cnt - base), 64'd4);
          chk("arready_full", ARREADY, 1'b0);
          chk("rvalid_full", RVALID, 1'b1);
          tick();
          RREADY = 1'b1;
        end
      join
      drain();
      chk("ar_accepted_all", 64'(ar_cnt - base), 64'd6);
    end

    // AW three cycles before W, B held for five cycles
    BREADY = 1'b0;
    do_aw(32'h24);
    chk("have_aw_readies", {AWREADY, WREADY}, 2'b01);
    repeat (2) tick();
    chk("have_aw_wait", {AWREADY, WREADY, BVALID}, 3'b010);
    do_w(32'hA5A5_0F0F, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("aw_first_b_held", {BVALID, BRESP, AWREADY, WREADY}, 5'b1_00_00);
      tick();
    end
    BREADY = 1'b1;
    tick();
    chk("aw_first_b_done", {BVALID, AWREADY, WREADY}, 3'b011);

    // W three cycles before AW
    BREADY = 1'b0;
    do_w(32'h1234_5678, 4'b1100);
    chk("have_w_readies", {AWREADY, WREADY}, 2'b10);
    repeat (2) tick();
    do_aw(32'h28);
    for (int i = 0; i < 5; i++) begin
      chk("w_first_b_held", {BVALID, BRESP, AWREADY, WREADY}, 5'b1_00_00);
      tick();
    end
    BREADY = 1'b1;
    tick();
    chk("w_first_b_done", {BVALID, AWREADY, WREADY}, 3'b011);
    drain();

    // Out of range just past the last word
    fork
      do_aw(32'(MW * 4));
      do_w(32'hFFFF_FFFF, 4'hF);
    join
    chk("oor_bresp", {BVALID, BRESP}, 3'b110);
    do_ar(32'(MW * 4));
    repeat (LAT - 1) tick();
    chk("oor_rresp", {RVALID, RRESP}, 3'b110);
    chk("oor_rdata", RDATA, 32'h0);
    drain();
    do_ar(32'h0);
    repeat (LAT - 1) tick();
    chk("word0_unchanged", RDATA, m_word(0));
    drain();

    // Reset with reads in flight and an AW held
    RREADY = 1'b0;
    for (int i = 0; i < 3; i++) do_ar(32'(i * 4));
    do_aw(32'h30);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_valids", {RVALID, BVALID}, 2'b00);
    chk("mid_rst_readies", {ARREADY, AWREADY, WREADY}, 3'b111);
    rexp.delete(); bexp.delete(); aw_q.delete(); wd_q.delete(); ws_q.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    RREADY = 1'b1;
    BREADY = 1'b1;
    repeat (10) tick();
    chk("post_rst_quiet", {RVALID, BVALID, ARREADY, AWREADY, WREADY}, 5'b00111);

    // Randomized traffic with random back-pressure
    fork
      begin
        fork
          begin
            for (int i = 0; i < 150; i++) begin
              repeat ($urandom_range(0, 2)) tick();
              do_ar(rand_addr());
            end
          end
          begin
            for (int i = 0; i < 60; i++) begin
              repeat ($urandom_range(0, 3)) tick();
              do_aw(rand_addr());
            end
          end
          begin
            for (int i = 0; i < 60; i++) begin
              repeat ($urandom_range(0, 3)) tick();
              do_w($urandom, 4'($urandom));
            end
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          RREADY = ($urandom_range(0, 3) != 0);
          BREADY = ($urandom_range(0, 1) != 0);
        end
      end
    join
    drain();

    // Read back every word the random phase may have touched
    for (int k = 0; k < 16; k++) do_ar(32'(k * 4));
    drain();

    chk("end_rexp_empty", 64'(rexp.size()), 64'd0);
    chk("end_bexp_empty", 64'(bexp.size()), 64'd0);
    chk("end_readies", {ARREADY, AWREADY, WREADY}, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
